serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if -- handshake/operand/result bundle for serial_adder_ctrl.
//   start, a, b, cin : request side, driven by the master
//   busy, done       : status, driven by the slave (adder)
//   sum, cout        : registered result, driven by the slave
//   overflow         : signed overflow, only when SERIAL_ADDER_OVERFLOW_EN is defined
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             overflow;

    modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, overflow);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder: one full adder reused over WIDTH
// cycles, LSB first, wrapped in an IDLE/RUN/DONE controller.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_ctrl_if.slave (start/a/b/cin in; busy/done/sum/cout out)
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds the registered
// two's-complement overflow output (bus.overflow).
// Timing: start accepted at edge k -> busy for WIDTH cycles -> done for one
// cycle after edge k+WIDTH. start in DONE restarts with no IDLE cycle.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s, fa_c, last_bit;

    // The single shared full adder, fed by the LSBs of the shift registers.
    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // start is not looked at here: the operation in flight runs to completion.
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                if (last_bit) begin
                    // Counter holds at WIDTH-1 rather than wrapping.
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // carry_q is the carry into the MSB, fa_c the carry out of it.
                    ovf_d   = carry_q ^ fa_c;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl -- directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Overflow checks are compiled in only when SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVERFLOW_EN
        return bus.overflow;
`else
        return 1'b0;
`endif
    endfunction

    // Launch one addition at a negedge, release start after the accepting edge,
    // then watch until done. lat counts negedges after the accepting edge (expect 8).
    // If poke is set, a second start with other operands is pulsed mid-RUN.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input bit poke);
        int lat;
        int busy_cnt;
        logic [7:0] sum_before;
        bit sum_moved;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sum_before = bus.sum;
        sum_moved = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            if (bus.sum !== sum_before) sum_moved = 1'b1;
            if (poke && lat == 3) begin
                bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busycnt"}, busy_cnt, 8);
        chk({tag, "_hold"}, {31'd0, sum_moved}, 0);
        chk({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk({tag, "_ovf"}, {31'd0, get_ovf()}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) chk({tag, "_ovf_unused"}, 0, 1);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 0);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #12;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_sum",  {24'd0, bus.sum}, 0);
        chk("rst_cout", {31'd0, bus.cout}, 0);
        chk("rst_ovf",  {31'd0, get_ovf()}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("v0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        run_op("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("vffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("v7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("v80ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("v0503", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("poke",  8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1);

        // Reset in the 4th RUN cycle: outputs clear at once, no done afterwards.
        @(negedge clk);
        bus.a = 8'h21; bus.b = 8'h43; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 0);
        chk("arst_done", {31'd0, bus.done}, 0);
        chk("arst_sum",  {24'd0, bus.sum}, 0);
        chk("arst_cout", {31'd0, bus.cout}, 0);
        chk("arst_ovf",  {31'd0, get_ovf()}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("arst_no_done", {31'd0, saw_done}, 0);
        run_op("post_rst", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

        // Back-to-back: start held through RUN and DONE.
        @(negedge clk);
        bus.a = 8'h3C; bus.b = 8'h0A; bus.cin = 1'b0; bus.start = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_lat1", cyc, 8);
        chk("b2b_sum1", {24'd0, bus.sum}, 32'h46);
        chk("b2b_cout1", {31'd0, bus.cout}, 0);
        bus.a = 8'hC8; bus.b = 8'h64;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_no_idle", {31'd0, bus.busy}, 1);
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_gap", cyc, 9);
        chk("b2b_sum2", {24'd0, bus.sum}, 32'h2C);
        chk("b2b_cout2", {31'd0, bus.cout}, 1);
        @(negedge clk);
        chk("b2b_idle", {31'd0, bus.done | bus.busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
